// File: rtl/matrix_cplx_pkg.sv
// Shared types and constants for the 4x4 complex operand stream loader.
package matrix_cplx_pkg;

    localparam int N     = 4;
    localparam int ELEMS = 16;
    localparam int W     = 16;

    localparam logic [3:0] LAST_IDX = 4'(ELEMS - 1);

    typedef logic signed [W-1:0] elem_t;
    typedef elem_t [0:N-1][0:N-1] mat_t;

    typedef enum logic [1:0] {
        FILL_A,
        FILL_B,
        HOLD
    } ld_state_t;

endpackage

// File: rtl/matrix_cplx_stream_loader_if.sv
// Stream-in / frame-out bundle between the element source, the loader and the 4x4 multiplier.
interface matrix_cplx_stream_loader_if
    import matrix_cplx_pkg::*;
#(
    parameter int w = W
);

    logic                        s_valid;
    logic                        s_ready;
    logic signed [w-1:0]         s_re;
    logic signed [w-1:0]         s_im;
    logic                        s_last;
    logic                        m_valid;
    logic                        m_ready;
    logic [0:N-1][0:N-1][w-1:0]  A_real;
    logic [0:N-1][0:N-1][w-1:0]  A_imag;
    logic [0:N-1][0:N-1][w-1:0]  B_real;
    logic [0:N-1][0:N-1][w-1:0]  B_imag;
    logic                        err_len;

    modport slave (
        input  s_valid, s_re, s_im, s_last, m_ready,
        output s_ready, m_valid, A_real, A_imag, B_real, B_imag, err_len
    );

    modport master (
        output s_valid, s_re, s_im, s_last, m_ready,
        input  s_ready, m_valid, A_real, A_imag, B_real, B_imag, err_len
    );

endinterface

// File: rtl/matrix_cplx_bank.sv
// One A+B operand register bank; a single element is written per enabled cycle at row idx[3:2], col idx[1:0].
module matrix_cplx_bank
    import matrix_cplx_pkg::*;
#(
    parameter int w = W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic                       sel_b,
    input  logic [3:0]                 idx,
    input  logic signed [w-1:0]        d_re,
    input  logic signed [w-1:0]        d_im,
    output logic [0:N-1][0:N-1][w-1:0] a_re,
    output logic [0:N-1][0:N-1][w-1:0] a_im,
    output logic [0:N-1][0:N-1][w-1:0] b_re,
    output logic [0:N-1][0:N-1][w-1:0] b_im
);

    logic [0:N-1][0:N-1][w-1:0] a_re_q, a_re_d;
    logic [0:N-1][0:N-1][w-1:0] a_im_q, a_im_d;
    logic [0:N-1][0:N-1][w-1:0] b_re_q, b_re_d;
    logic [0:N-1][0:N-1][w-1:0] b_im_q, b_im_d;
    logic [1:0]                 row;
    logic [1:0]                 col;

    assign row = idx[3:2];
    assign col = idx[1:0];

    always_comb begin
        a_re_d = a_re_q;
        a_im_d = a_im_q;
        b_re_d = b_re_q;
        b_im_d = b_im_q;
        if (we) begin
            if (sel_b) begin
                b_re_d[row][col] = d_re;
                b_im_d[row][col] = d_im;
            end else begin
                a_re_d[row][col] = d_re;
                a_im_d[row][col] = d_im;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_re_q <= '0;
            a_im_q <= '0;
            b_re_q <= '0;
            b_im_q <= '0;
        end else begin
            a_re_q <= a_re_d;
            a_im_q <= a_im_d;
            b_re_q <= b_re_d;
            b_im_q <= b_im_d;
        end
    end

    assign a_re = a_re_q;
    assign a_im = a_im_q;
    assign b_re = b_re_q;
    assign b_im = b_im_q;

endmodule

// File: rtl/matrix_cplx_stream_loader.sv
// Serial complex element stream -> registered 4x4 A/B operand frame with valid/ready hand-off.
// Optional LOADER_PINGPONG_EN: two banks so filling the next frame overlaps presenting the current one.
module matrix_cplx_stream_loader
    import matrix_cplx_pkg::*;
#(
    parameter int w = W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    matrix_cplx_stream_loader_if.slave   bus
);

`ifdef LOADER_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif

    ld_state_t  state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       run_q, run_d;
    logic       err_q, err_d;
    logic [1:0] full_q, full_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;

    logic       xfer;
    logic       accept;
    logic       frame_done;
    logic       sel_b;

    logic [0:N-1][0:N-1][w-1:0] ar0, ai0, br0, bi0;

    // run_q keeps s_ready low while reset is asserted and for the first edge after release
    assign bus.s_ready = run_q && (state_q != HOLD);
    assign bus.m_valid = full_q[rd_q];
    assign bus.err_len = err_q;

    assign xfer       = bus.s_valid && bus.s_ready;
    assign accept     = bus.m_valid && bus.m_ready;
    assign sel_b      = (state_q == FILL_B);
    assign frame_done = xfer && sel_b && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = 1'b1;
        err_d   = 1'b0;
        full_d  = full_q;
        wr_d    = wr_q;
        rd_d    = rd_q;

        if (accept) begin
            full_d[rd_q] = 1'b0;
            rd_d         = PINGPONG ? ~rd_q : rd_q;
        end

        if (xfer) begin
            if (bus.s_last && !frame_done) begin
                state_d = FILL_A;
                idx_d   = '0;
                err_d   = 1'b1;
            end else if (frame_done) begin
                idx_d        = '0;
                err_d        = !bus.s_last;
                full_d[wr_q] = 1'b1;
                wr_d         = PINGPONG ? ~wr_q : wr_q;
                // A same-cycle accept of the other bank frees it, so filling continues without a bubble
                state_d      = full_d[wr_d] ? HOLD : FILL_A;
            end else begin
                idx_d = idx_q + 4'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = FILL_B;
                end
            end
        end else if ((state_q == HOLD) && !full_d[wr_q]) begin
            state_d = FILL_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL_A;
            idx_q   <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            err_q   <= err_d;
            full_q  <= full_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

`ifdef LOADER_PINGPONG_EN
    logic [0:N-1][0:N-1][w-1:0] ar1, ai1, br1, bi1;

    matrix_cplx_bank #(.w(w)) u_bank0 (
        .clk(clk), .rst_n(rst_n), .we(xfer && !wr_q), .sel_b(sel_b), .idx(idx_q),
        .d_re(bus.s_re), .d_im(bus.s_im),
        .a_re(ar0), .a_im(ai0), .b_re(br0), .b_im(bi0)
    );

    matrix_cplx_bank #(.w(w)) u_bank1 (
        .clk(clk), .rst_n(rst_n), .we(xfer && wr_q), .sel_b(sel_b), .idx(idx_q),
        .d_re(bus.s_re), .d_im(bus.s_im),
        .a_re(ar1), .a_im(ai1), .b_re(br1), .b_im(bi1)
    );

    assign bus.A_real = rd_q ? ar1 : ar0;
    assign bus.A_imag = rd_q ? ai1 : ai0;
    assign bus.B_real = rd_q ? br1 : br0;
    assign bus.B_imag = rd_q ? bi1 : bi0;
`else
    matrix_cplx_bank #(.w(w)) u_bank0 (
        .clk(clk), .rst_n(rst_n), .we(xfer), .sel_b(sel_b), .idx(idx_q),
        .d_re(bus.s_re), .d_im(bus.s_im),
        .a_re(ar0), .a_im(ai0), .b_re(br0), .b_im(bi0)
    );

    assign bus.A_real = ar0;
    assign bus.A_imag = ai0;
    assign bus.B_real = br0;
    assign bus.B_imag = bi0;
`endif

endmodule
